// File: rtl/tpu_pkg.sv
// Shared TPU types: byte lanes, weight addresses and the
// weight stream engine state encoding.
package tpu_pkg;

   typedef logic [7:0]  byte_type;
   typedef logic [15:0] weight_addr_type;

   localparam int WEIGHT_BUFFER_READ_LATENCY = 3;

   typedef enum logic [1:0] {
      WS_IDLE,
      WS_ISSUE,
      WS_DRAIN
   } weight_stream_state_type;

endpackage

// File: rtl/weight_read_delay.sv
// Fixed-depth data/valid/last delay line; data stages only move
// on valid so the output row holds between reads.
module weight_read_delay #(
   parameter int LAT = 3,
   parameter int W   = 64
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_enable,
   input  logic         i_valid,
   input  logic         i_last,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic         o_last,
   output logic [W-1:0] o_data
);

   logic [LAT-1:0] r_v;
   logic [LAT-1:0] r_l;
   logic [W-1:0]   r_d [LAT];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v <= '0;
         r_l <= '0;
         for (int k = 0; k < LAT; k++) r_d[k] <= '0;
      end else if (i_enable) begin
         r_v[0] <= i_valid;
         r_l[0] <= i_valid & i_last;
         if (i_valid) r_d[0] <= i_data;
         for (int k = 1; k < LAT; k++) begin
            r_v[k] <= r_v[k-1];
            r_l[k] <= r_l[k-1];
            if (r_v[k-1]) r_d[k] <= r_d[k-1];
         end
      end
   end

   assign o_valid = r_v[LAT-1];
   assign o_last  = r_l[LAT-1];
   assign o_data  = r_d[LAT-1];

endmodule

// File: rtl/weight_buffer_stream.sv
// Dual-port weight memory: host random-access port 0, and port 1
// host writes plus a burst engine streaming rows to the weight FIFO.
module weight_buffer_stream
   import tpu_pkg::*;
#(
   parameter int MATRIX_WIDTH = 8,
   parameter int TILE_WIDTH   = 64,
   parameter int READ_LATENCY = WEIGHT_BUFFER_READ_LATENCY,
   parameter int ADDR_WIDTH   = $clog2(MATRIX_WIDTH*TILE_WIDTH)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  weight_addr_type                   addr0,
   input  logic                              en0,
   input  logic                              write_en0,
   input  logic [MATRIX_WIDTH-1:0]           byte_mask0,
   input  byte_type [MATRIX_WIDTH-1:0]       write_port0,
   output byte_type [MATRIX_WIDTH-1:0]       read_port0,
   input  weight_addr_type                   addr1,
   input  logic                              write_en1,
   input  byte_type [MATRIX_WIDTH-1:0]       write_port1,
   input  logic                              burst_start,
   input  weight_addr_type                   burst_addr,
   input  logic [ADDR_WIDTH:0]               burst_len,
   output logic                              burst_busy,
   output logic                              stream_valid,
   output byte_type [MATRIX_WIDTH-1:0]       stream_data,
   output logic                              stream_last,
   output logic                              wr_reject
);

   localparam int DEPTH = MATRIX_WIDTH * TILE_WIDTH;
   localparam int RW    = 8 * MATRIX_WIDTH;

   typedef byte_type [MATRIX_WIDTH-1:0] row_t;

   function automatic logic [ADDR_WIDTH-1:0] wrap(weight_addr_type a);
      return ADDR_WIDTH'(a % weight_addr_type'(DEPTH));
   endfunction

   row_t r_mem [DEPTH];

   weight_stream_state_type r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_ptr, w_ptr_nxt;
   logic [ADDR_WIDTH:0]     r_cnt, w_cnt_nxt;
   logic                    r_zero_last, w_zero_last;
   logic                    r_wr_reject;
   logic                    r_rd0_v, r_st_v, r_st_l;
   row_t                    r_rd0_d, r_st_d;
   logic                    w_iss, w_iss_last;
   logic                    w_busy, w_wr1;
   logic [ADDR_WIDTH-1:0]   w_a0, w_a1;
   logic                    w_rd0_valid, w_rd0_last;
   logic                    w_st_valid, w_st_last;
   logic                    w_unused_rd0;

   assign w_a0   = wrap(addr0);
   assign w_a1   = wrap(addr1);
   assign w_busy = (r_state != WS_IDLE);
   assign w_wr1  = write_en1 & ~w_busy;

   // Port 0 is applied last so its masked lanes win a same-row collision.
   always_ff @(posedge clk) begin
      if (enable) begin
         if (w_wr1) r_mem[w_a1] <= write_port1;
         if (en0 && write_en0) begin
            for (int j = 0; j < MATRIX_WIDTH; j++)
               if (byte_mask0[j]) r_mem[w_a0][j] <= write_port0[j];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_iss       = 1'b0;
      w_iss_last  = 1'b0;
      w_zero_last = 1'b0;
      unique case (r_state)
         WS_IDLE: begin
            if (burst_start) begin
               if (burst_len != '0) begin
                  w_state_nxt = WS_ISSUE;
                  w_ptr_nxt   = wrap(burst_addr);
                  w_cnt_nxt   = burst_len;
               end else begin
                  w_zero_last = 1'b1;
               end
            end
         end
         WS_ISSUE: begin
            w_iss      = 1'b1;
            w_iss_last = (r_cnt == (ADDR_WIDTH+1)'(1));
            w_ptr_nxt  = (r_ptr == ADDR_WIDTH'(DEPTH-1)) ? '0 : r_ptr + 1'b1;
            w_cnt_nxt  = r_cnt - 1'b1;
            if (w_iss_last) w_state_nxt = WS_DRAIN;
         end
         WS_DRAIN: begin
            if (w_st_valid && w_st_last) w_state_nxt = WS_IDLE;
         end
         default: w_state_nxt = WS_IDLE;
      endcase
   end

   // Memory output registers sample at the request edge (read-first).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= WS_IDLE;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_zero_last <= 1'b0;
         r_wr_reject <= 1'b0;
         r_rd0_v     <= 1'b0;
         r_rd0_d     <= '0;
         r_st_v      <= 1'b0;
         r_st_l      <= 1'b0;
         r_st_d      <= '0;
      end else if (enable) begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_cnt       <= w_cnt_nxt;
         r_zero_last <= w_zero_last;
         r_wr_reject <= write_en1 & w_busy;
         r_rd0_v     <= en0 & ~write_en0;
         if (en0 && !write_en0) r_rd0_d <= r_mem[w_a0];
         r_st_v      <= w_iss;
         r_st_l      <= w_iss_last;
         if (w_iss) r_st_d <= r_mem[r_ptr];
      end
   end

   weight_read_delay #(.LAT(READ_LATENCY), .W(RW)) u_rd0_dly (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_enable (enable),
      .i_valid  (r_rd0_v),
      .i_last   (1'b0),
      .i_data   (r_rd0_d),
      .o_valid  (w_rd0_valid),
      .o_last   (w_rd0_last),
      .o_data   (read_port0)
   );

   weight_read_delay #(.LAT(READ_LATENCY), .W(RW)) u_st_dly (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_enable (enable),
      .i_valid  (r_st_v),
      .i_last   (r_st_l),
      .i_data   (r_st_d),
      .o_valid  (w_st_valid),
      .o_last   (w_st_last),
      .o_data   (stream_data)
   );

   assign w_unused_rd0 = w_rd0_valid | w_rd0_last;
   assign stream_valid = w_st_valid;
   assign stream_last  = w_st_last | r_zero_last;
   assign burst_busy   = w_busy;
   assign wr_reject    = r_wr_reject;

endmodule

// File: tb/tb_weight_buffer_stream.sv
// Self-checking bench for weight_buffer_stream: port 0 vector table,
// burst scoreboard and hand-written freeze/reset/collision sequences.
module tb_weight_buffer_stream;

   localparam int MW    = 8;
   localparam int DEPTH = 512;
   localparam int AW    = 9;
   localparam int LAT   = 3;

   typedef logic [MW-1:0][7:0] row_t;
   typedef struct {longint unsigned due; row_t d;} p0_t;
   typedef struct {row_t d; logic last;} st_t;
   typedef struct {
      logic [15:0] a0; logic en0; logic we0; logic [7:0] m0; row_t d0;
      logic we1; logic [15:0] a1; row_t d1; row_t exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, enable;
   logic [15:0] addr0, addr1, burst_addr;
   logic        en0, write_en0, write_en1, burst_start;
   logic [7:0]  byte_mask0;
   row_t        write_port0, write_port1, read_port0, stream_data;
   logic [AW:0] burst_len;
   logic        burst_busy, stream_valid, stream_last, wr_reject;

   int checks = 0;
   int failures = 0;
   longint unsigned cyc = 0;
   logic edge_en = 1'b0;
   int zl_cnt = 0;
   int last_cnt = 0;

   row_t mdl [DEPTH];
   p0_t  q0 [$];
   st_t  q1 [$];

   weight_buffer_stream dut (
      .clk(clk), .rst(rst), .enable(enable),
      .addr0(addr0), .en0(en0), .write_en0(write_en0),
      .byte_mask0(byte_mask0), .write_port0(write_port0),
      .read_port0(read_port0),
      .addr1(addr1), .write_en1(write_en1), .write_port1(write_port1),
      .burst_start(burst_start), .burst_addr(burst_addr),
      .burst_len(burst_len), .burst_busy(burst_busy),
      .stream_valid(stream_valid), .stream_data(stream_data),
      .stream_last(stream_last), .wr_reject(wr_reject)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic row_t pat(int i);
      row_t r;
      for (int j = 0; j < MW; j++) r[j] = 8'((i * j) & 255);
      return r;
   endfunction

   always @(posedge clk) begin
      edge_en <= enable;
      if (enable) cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      p0_t e0;
      st_t e1;
      if (edge_en) begin
         if (q0.size() > 0 && q0[0].due == cyc) begin
            e0 = q0.pop_front();
            chk("p0_read", read_port0, e0.d);
         end
         if (stream_valid) begin
            if (stream_last) last_cnt++;
            if (q1.size() == 0) begin
               chk("stream_extra", 64'd1, 64'd0);
            end else begin
               e1 = q1.pop_front();
               chk("stream_data", stream_data, e1.d);
               chk("stream_last", 64'(stream_last), 64'(e1.last));
            end
         end else if (stream_last) begin
            zl_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd0(input int a, input row_t exp);
      en0 = 1'b1; write_en0 = 1'b0; addr0 = 16'(a);
      q0.push_back('{cyc + 1 + LAT, exp});
      tick();
      en0 = 1'b0;
   endtask

   task automatic drain_q0();
      for (int k = 0; k < 20 && q0.size() > 0; k++) tick();
      chk("p0_drain", 64'(q0.size()), 64'd0);
   endtask

   task automatic start_burst(input int a, input int len);
      burst_start = 1'b1;
      burst_addr  = 16'(a);
      burst_len   = (AW+1)'(len);
      for (int i = 0; i < len; i++)
         q1.push_back('{mdl[(a + i) % DEPTH], i == len - 1});
      tick();
      burst_start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, output int t_first,
                            output int t_last, output int t_idle);
      t_first = -1; t_last = -1; t_idle = -1;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (stream_valid && t_first < 0) t_first = k;
         if (stream_valid && stream_last) t_last = k;
         if (!burst_busy) begin
            t_idle = k;
            break;
         end
      end
      chk(nm, 64'(t_idle >= 0), 64'd1);
   endtask

   vec_t tbl [6];
   int tf, tl, ti, zl0, lc0;
   row_t tmp, snap_d;
   logic snap_v, snap_b, snap_l;

   initial begin
      rst = 1'b1; enable = 1'b1;
      addr0 = '0; addr1 = '0; burst_addr = '0; burst_len = '0;
      en0 = 0; write_en0 = 0; write_en1 = 0; burst_start = 0;
      byte_mask0 = '0; write_port0 = '0; write_port1 = '0;

      // reset state
      repeat (3) tick();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_read_port0", read_port0, 64'd0);
         chk("rst_stream_valid", 64'(stream_valid), 64'd0);
         chk("rst_stream_data", stream_data, 64'd0);
         chk("rst_stream_last", 64'(stream_last), 64'd0);
         chk("rst_busy", 64'(burst_busy), 64'd0);
         chk("rst_wr_reject", 64'(wr_reject), 64'd0);
      end

      // fill memory through port 0
      en0 = 1'b1; write_en0 = 1'b1; byte_mask0 = 8'hFF;
      for (int i = 0; i < DEPTH; i++) begin
         addr0 = 16'(i); write_port0 = pat(i); mdl[i] = pat(i);
         tick();
      end
      en0 = 1'b0; write_en0 = 1'b0;

      tmp = pat(5); tmp[1] = 8'hAA;
      tbl[0] = '{16'd5,   1, 0, 8'h00, '0, 0, 16'd0,  '0, pat(5)};
      tbl[1] = '{16'd5,   1, 1, 8'h02, {MW{8'hAA}}, 0, 16'd0, '0, '0};
      tbl[2] = '{16'd5,   1, 0, 8'h00, '0, 0, 16'd0,  '0, tmp};
      tbl[3] = '{16'd519, 1, 0, 8'h00, '0, 0, 16'd0,  '0, pat(7)};
      tbl[4] = '{16'd10,  1, 0, 8'h00, '0, 1, 16'd10, {MW{8'h55}}, pat(10)};
      tbl[5] = '{16'd10,  1, 0, 8'h00, '0, 0, 16'd0,  '0, {MW{8'h55}}};
      for (int v = 0; v < 6; v++) begin
         en0 = tbl[v].en0; write_en0 = tbl[v].we0; addr0 = tbl[v].a0;
         byte_mask0 = tbl[v].m0; write_port0 = tbl[v].d0;
         write_en1 = tbl[v].we1; addr1 = tbl[v].a1;
         write_port1 = tbl[v].d1;
         if (tbl[v].en0 && !tbl[v].we0)
            q0.push_back('{cyc + 1 + LAT, tbl[v].exp});
         if (tbl[v].we1) mdl[tbl[v].a1 % DEPTH] = tbl[v].d1;
         if (tbl[v].en0 && tbl[v].we0)
            for (int j = 0; j < MW; j++)
               if (tbl[v].m0[j]) mdl[tbl[v].a0 % DEPTH][j] = tbl[v].d0[j];
         tick();
      end
      en0 = 0; write_en0 = 0; write_en1 = 0;
      drain_q0();
      rd0(511, pat(511));
      drain_q0();

      // wrapping burst
      start_burst(DEPTH - 2, 4);
      wait_idle("burst_wrap_idle", tf, tl, ti);
      chk("burst_wrap_span", 64'(tl - tf), 64'd3);
      chk("burst_busy_fall", 64'(ti), 64'(tl + 1));
      chk("burst_wrap_q", 64'(q1.size()), 64'd0);

      // rejected host write during a burst
      start_burst(20, 6);
      write_en1 = 1'b1; addr1 = 16'd20; write_port1 = {MW{8'hEE}};
      tick();
      write_en1 = 1'b0;
      chk("wr_reject_pulse", 64'(wr_reject), 64'd1);
      tick();
      chk("wr_reject_clear", 64'(wr_reject), 64'd0);
      wait_idle("burst_rej_idle", tf, tl, ti);
      rd0(20, pat(20));
      drain_q0();

      // zero-length burst
      zl0 = zl_cnt;
      start_burst(7, 0);
      chk("zl_last", 64'(stream_last), 64'd1);
      chk("zl_valid", 64'(stream_valid), 64'd0);
      chk("zl_busy", 64'(burst_busy), 64'd0);
      tick();
      chk("zl_last_fall", 64'(stream_last), 64'd0);
      repeat (3) tick();
      chk("zl_count", 64'(zl_cnt - zl0), 64'd1);
      chk("zl_busy_after", 64'(burst_busy), 64'd0);

      // freeze mid-burst
      start_burst(100, 8);
      repeat (5) tick();
      snap_v = stream_valid; snap_d = stream_data;
      snap_b = burst_busy;   snap_l = stream_last;
      enable = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("frz_valid", 64'(stream_valid), 64'(snap_v));
         chk("frz_data", stream_data, snap_d);
         chk("frz_busy", 64'(burst_busy), 64'(snap_b));
         chk("frz_last", 64'(stream_last), 64'(snap_l));
      end
      enable = 1'b1;
      wait_idle("frz_idle", tf, tl, ti);
      chk("frz_q", 64'(q1.size()), 64'd0);

      // same-row collision on both ports
      en0 = 1'b1; write_en0 = 1'b1; addr0 = 16'd30; byte_mask0 = 8'h03;
      write_port0 = {MW{8'h11}};
      write_en1 = 1'b1; addr1 = 16'd30; write_port1 = {MW{8'h22}};
      tick();
      en0 = 0; write_en0 = 0; write_en1 = 0;
      tmp = {MW{8'h22}}; tmp[0] = 8'h11; tmp[1] = 8'h11;
      mdl[30] = tmp;
      rd0(30, 64'h2222_2222_2222_1111);
      drain_q0();

      // reset mid-burst
      lc0 = last_cnt;
      start_burst(40, 10);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      q1.delete();
      chk("rstb_valid", 64'(stream_valid), 64'd0);
      chk("rstb_last", 64'(stream_last), 64'd0);
      chk("rstb_busy", 64'(burst_busy), 64'd0);
      rst = 1'b0;
      repeat (12) tick();
      chk("rstb_no_last", 64'(last_cnt - lc0), 64'd0);
      chk("final_q0", 64'(q0.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
